cell_pos_pingpong_mem: RTL

Double-buffered per-cell particle position memory and the parametrised successor of the single-bank cell position RAMs. One bank serves force-evaluation reads while motion update appends new positions to the other; a swap command makes the freshly written bank readable in one cycle. Particle count is kept in hardware per bank and is exposed at address 0, so readers still see the layout {count at 0, particles at 1..N}. Sits between the position cache and the motion update unit, one instance per cell.

---
 rtl/cell_pos_pingpong_mem_if.sv | 28 ++
 rtl/cell_pos_pingpong_mem.sv | 114 +++++++++++
 2 files changed

// File: rtl/cell_pos_pingpong_mem_if.sv
// Bus bundle for the double-buffered cell position memory.
// master = position cache / motion update side, slave = the memory.
interface cell_pos_pingpong_mem_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  swap;
  logic [ADDR_WIDTH-1:0] rd_count;
  logic [ADDR_WIDTH-1:0] wr_count;
  logic                  overflow;
  logic                  active_bank;

  modport master (
    output rd_en, rd_addr, wr_en, wr_data, swap,
    input  rd_data, rd_valid, rd_count, wr_count, overflow, active_bank
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_data, swap,
    output rd_data, rd_valid, rd_count, wr_count, overflow, active_bank
  );
endinterface

// File: rtl/cell_pos_pingpong_mem.sv
// Ping-pong per-cell position RAM: one bank read, the other appended, swap flips them.
// Latency: read 2 cycles (registered address, registered data); append/swap visible next cycle.
// Backpressure: none; appends beyond PARTICLE_NUM-1 are dropped and flag sticky overflow.
module cell_pos_pingpong_mem #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   rst,
  cell_pos_pingpong_mem_if.slave bus
);
  localparam int MEM_AW = (PARTICLE_NUM > 1) ? $clog2(PARTICLE_NUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  logic [DATA_WIDTH-1:0] mem0 [PARTICLE_NUM];
  logic [DATA_WIDTH-1:0] mem1 [PARTICLE_NUM];

  logic [ADDR_WIDTH-1:0] count [2];
  logic                  active_bank;
  logic                  overflow;
  logic                  wr_bank;
  logic [ADDR_WIDTH-1:0] rd_count;
  logic [ADDR_WIDTH-1:0] wr_count;
  logic                  full;
  logic                  do_write;
  logic [MEM_AW-1:0]     wr_ptr;

  assign wr_bank  = ~active_bank;
  assign rd_count = count[active_bank];
  assign wr_count = count[wr_bank];
  assign full     = (wr_count == FULL_COUNT);
  assign do_write = bus.wr_en && !full;
  // Address 0 holds the count, so particle k lives at address k.
  assign wr_ptr   = MEM_AW'(wr_count + 1'b1);

  always_ff @(posedge clock) begin
    if (rst) begin
      count[0]    <= '0;
      count[1]    <= '0;
      active_bank <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        if (full) overflow <= 1'b1;
        else      count[wr_bank] <= wr_count + 1'b1;
      end
      // The retiring read bank becomes the write bank and starts empty.
      if (bus.swap) begin
        count[active_bank] <= '0;
        active_bank        <= ~active_bank;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_write && wr_bank)  mem1[wr_ptr] <= bus.wr_data;
    if (do_write && !wr_bank) mem0[wr_ptr] <= bus.wr_data;
  end

  logic                  rd_vld_q;
  logic                  rd_bank_q;
  logic                  rd_zero_q;
  logic                  rd_hit_q;
  logic [MEM_AW-1:0]     rd_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_cnt_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  // Bank, count and range test are frozen at issue so a later swap cannot redirect the read.
  always_ff @(posedge clock) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_zero_q <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_ptr_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      rd_vld_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_bank_q <= active_bank;
        rd_zero_q <= (bus.rd_addr == '0);
        rd_hit_q  <= (bus.rd_addr != '0) && (bus.rd_addr <= rd_count);
        rd_ptr_q  <= MEM_AW'(bus.rd_addr);
        rd_cnt_q  <= rd_count;
      end
    end
  end

  assign rd_word = rd_bank_q ? mem1[rd_ptr_q] : mem0[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_vld_q;
      if (rd_vld_q) begin
        if (rd_zero_q)     rd_data_q <= DATA_WIDTH'(rd_cnt_q);
        else if (rd_hit_q) rd_data_q <= rd_word;
        else               rd_data_q <= '0;
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_count    = rd_count;
  assign bus.wr_count    = wr_count;
  assign bus.overflow    = overflow;
  assign bus.active_bank = active_bank;
endmodule
